// File: rtl/fpmd_pkg.sv
// fpmd_pkg: types and constants shared by the FP mult/div result path.
// Holds the IEEE-754 flag vector layout, the buffered result entry and the
// default core latency.
package fpmd_pkg;

  // Core flags {io, dz, of, uf, i}, msb first.
  typedef logic [4:0] fp_flags_t;

  localparam int unsigned IO = 4;
  localparam int unsigned DZ = 3;
  localparam int unsigned OF = 2;
  localparam int unsigned UF = 1;
  localparam int unsigned I  = 0;

  // Cycles from operand issue to valid R/flags on the mult/div core.
  localparam int unsigned R_DLY_DEFAULT = 23;

  // One buffered result.
  typedef struct packed {
    logic [31:0] data;
    fp_flags_t   flags;
    logic        sel;
  } result_t;

  // Next sticky value: a clear wins over history but keeps the flags that
  // arrive in the same cycle.
  function automatic fp_flags_t sticky_next(
    input fp_flags_t cur,
    input logic      clr,
    input logic      push,
    input fp_flags_t flags
  );
    fp_flags_t add;
    add = push ? flags : '0;
    return clr ? add : (cur | add);
  endfunction

endpackage

// File: rtl/fpmd_sync_fifo.sv
// fpmd_sync_fifo: first-word-fall-through result buffer.
// rd_data shows the head entry whenever empty=0; a push into a full buffer
// is taken only when a pop happens at the same edge.
module fpmd_sync_fifo
  import fpmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     wr_en,
  input  result_t                  wr_data,
  input  logic                     rd_en,
  output result_t                  rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  result_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    occ;
  logic           do_push;
  logic           do_pop;

  // Qualify the handshakes against the current occupancy.
  always_comb begin
    do_pop  = rd_en && (occ != '0);
    do_push = wr_en && ((occ != DEPTH_C) || do_pop);
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap natural.
  always_ff @(posedge clk) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW + 1)'(1);
        2'b01:   occ <= occ - (AW + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage array, left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (occ == DEPTH_C);
  assign empty   = (occ == '0);
  assign count   = occ;

endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector: captures mult/div core results R_DLY cycles after
// issue, buffers them in issue order and hands them out over valid/ready.
// Credit-based issue control guarantees the buffer never overflows.
// Optional feature: define FPMD_STICKY_FLAGS_EN to build the sticky flag
// accumulator; otherwise sticky_flags is tied to zero.
module fp_result_collector
  import fpmd_pkg::*;
#(
  parameter int unsigned R_DLY = R_DLY_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        en,
  input  logic        sel,
  input  logic [31:0] R,
  input  logic [4:0]  core_flags,
  output logic        issue_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_flags,
  output logic        out_sel,
  input  logic        sticky_clr,
  output logic [4:0]  sticky_flags,
  output logic        drop_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [R_DLY-1:0] dl_valid;
  logic [R_DLY-1:0] dl_sel;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    occ;
  logic             accept;
  logic             push;
  logic             full;
  logic             empty;
  result_t          push_entry;
  result_t          head;

  // Credits come from registered counters only, so a pop frees a slot one
  // cycle later.
  assign issue_ready = ({1'b0, inflight} + {1'b0, occ}) < DEPTH_C;
  assign accept      = en && issue_ready;
  assign push        = dl_valid[R_DLY-1];

  // Capture the core outputs together with the op type that left the line.
  always_comb begin
    push_entry       = '0;
    push_entry.data  = R;
    push_entry.flags = core_flags;
    push_entry.sel   = dl_sel[R_DLY-1];
  end

  // Valid/sel delay line matching the core latency.
  always_ff @(posedge clk) begin
    if (!arst) begin
      dl_valid <= '0;
      dl_sel   <= '0;
    end else begin
      dl_valid[0] <= accept;
      dl_sel[0]   <= sel;
      for (int unsigned k = 1; k < R_DLY; k++) begin
        dl_valid[k] <= dl_valid[k-1];
        dl_sel[k]   <= dl_sel[k-1];
      end
    end
  end

  // Ops issued but not yet written into the buffer.
  always_ff @(posedge clk) begin
    if (!arst) begin
      inflight <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky record of an issue attempted without credit.
  always_ff @(posedge clk) begin
    if (!arst) begin
      drop_err <= 1'b0;
    end else if (en && !issue_ready) begin
      drop_err <= 1'b1;
    end
  end

  fpmd_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (occ)
  );

  // Outputs read as zero while nothing is buffered (storage is unreset).
  always_comb begin
    out_valid = !empty;
    out_data  = empty ? '0   : head.data;
    out_flags = empty ? '0   : head.flags;
    out_sel   = empty ? 1'b0 : head.sel;
  end

  // Credits make a push into a full buffer impossible without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!arst)
    push |-> (!full || out_ready));

`ifdef FPMD_STICKY_FLAGS_EN
  fp_flags_t sticky;

  // Accumulate flags of every captured result since the last clear.
  always_ff @(posedge clk) begin
    if (!arst) begin
      sticky <= '0;
    end else begin
      sticky <= sticky_next(sticky, sticky_clr, push, core_flags);
    end
  end

  assign sticky_flags = sticky;
`else
  // No accumulator: a zero history with no push always yields zero, which
  // keeps sticky_clr connected without giving it any effect.
  assign sticky_flags = sticky_next('0, sticky_clr, 1'b0, '0);
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// tb_fp_result_collector: scoreboard bench for fp_result_collector.
// Issued ops are queued with their accept/push edges; a core model drives
// R/core_flags at the push edge and a monitor checks every output each cycle.
module tb_fp_result_collector;
  import fpmd_pkg::*;

  localparam int R_DLY = 23;
  localparam int DEPTH = 4;
  localparam int NEVER = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        en = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] R = '0;
  logic [4:0]  core_flags = '0;
  logic        issue_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_flags;
  logic        out_sel;
  logic        sticky_clr = 1'b0;
  logic [4:0]  sticky_flags;
  logic        drop_err;

  fp_result_collector #(
    .R_DLY (R_DLY),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .en           (en),
    .sel          (sel),
    .R            (R),
    .core_flags   (core_flags),
    .issue_ready  (issue_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .out_sel      (out_sel),
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] data;
    logic [4:0]  flags;
    logic        sel;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          accepted = 0;
  int          drop_edge = NEVER;
  int          last_due = 0;
  bit          mon_en = 1'b0;
  logic [4:0]  sticky_m = '0;

  // Monitor-only state
  int          inq;
  logic        m_valid;
  logic [31:0] m_data;
  logic [4:0]  m_flags;
  logic        m_sel;
  logic        m_push;
  logic [4:0]  m_pflags;
  logic [4:0]  sticky_exp;
  bit          core_found;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: present the queued result at its push edge, junk otherwise.
  always @(negedge clk) begin
    core_found = 1'b0;
    foreach (exp_q[k]) begin
      if (exp_q[k].due == cyc + 1) begin
        R          = exp_q[k].data;
        core_flags = exp_q[k].flags;
        core_found = 1'b1;
      end
    end
    if (!core_found) begin
      R          = $urandom;
      core_flags = 5'($urandom);
    end
  end

  // Scoreboard monitor: compare all outputs, then advance the model.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      inq = 0;
      foreach (exp_q[k]) if (exp_q[k].acc <= cyc) inq++;
      m_valid = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
      if (m_valid) begin
        m_data = exp_q[0].data; m_flags = exp_q[0].flags; m_sel = exp_q[0].sel;
      end else begin
        m_data = '0; m_flags = '0; m_sel = 1'b0;
      end
`ifdef FPMD_STICKY_FLAGS_EN
      sticky_exp = sticky_m;
`else
      sticky_exp = '0;
`endif
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid);
      end
      checks++;
      if (out_data !== m_data || out_flags !== m_flags || out_sel !== m_sel) begin
        errors++;
        $display("FAIL out_entry cyc=%0d got=%h/%b/%b exp=%h/%b/%b", cyc,
                 out_data, out_flags, out_sel, m_data, m_flags, m_sel);
      end
      checks++;
      if (issue_ready !== (inq < DEPTH)) begin
        errors++;
        $display("FAIL issue_ready cyc=%0d got=%b exp=%b", cyc, issue_ready, inq < DEPTH);
      end
      checks++;
      if (drop_err !== (drop_edge <= cyc)) begin
        errors++;
        $display("FAIL drop_err cyc=%0d got=%b exp=%b", cyc, drop_err, drop_edge <= cyc);
      end
      checks++;
      if (sticky_flags !== sticky_exp) begin
        errors++;
        $display("FAIL sticky_flags cyc=%0d got=%b exp=%b", cyc, sticky_flags, sticky_exp);
      end
      if (!arst) begin
        exp_q.delete();
        drop_edge = NEVER;
        sticky_m  = '0;
      end else begin
        m_push = 1'b0; m_pflags = '0;
        foreach (exp_q[k]) begin
          if (exp_q[k].due == cyc + 1) begin
            m_push = 1'b1; m_pflags = exp_q[k].flags;
          end
        end
        if (sticky_clr) sticky_m = m_push ? m_pflags : 5'b0;
        else if (m_push) sticky_m = sticky_m | m_pflags;
        if (m_valid && out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    en = 1'b0;
    sticky_clr = 1'b0;
  endtask

  // Present one issue for the coming edge; accepted only with credit.
  task automatic issue(input logic op, input logic [31:0] data, input logic [4:0] flags);
    exp_t e;
    @(negedge clk);
    en = 1'b1;
    sel = op;
    sticky_clr = 1'b0;
    if (exp_q.size() < DEPTH) begin
      e.acc = cyc + 1; e.due = cyc + 1 + R_DLY;
      e.data = data; e.flags = flags; e.sel = op;
      exp_q.push_back(e);
      last_due = e.due;
      accepted++;
    end else if (drop_edge > cyc + 1) begin
      drop_edge = cyc + 1;
    end
  endtask

  task automatic drain;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    arst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", out_data); end
    checks++; if (out_flags !== 5'h0 || out_sel !== 1'b0) begin errors++; $display("FAIL rst_flags_sel got=%b/%b exp=0/0", out_flags, out_sel); end
    checks++; if (sticky_flags !== 5'h0) begin errors++; $display("FAIL rst_sticky got=%b exp=0", sticky_flags); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop got=%b exp=0", drop_err); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", issue_ready); end
    @(negedge clk);
    arst = 1'b1;
    exp_q.delete();
    drop_edge = NEVER;
    sticky_m = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_latency;
    bit got = 1'b0;
    out_ready = 1'b1;
    issue(1'b0, 32'h40C00000, 5'b00000);
    for (int k = 0; k < R_DLY + 10 && !got; k++) begin
      tick(); #1;
      if (out_valid) got = 1'b1;
    end
    checks++;
    if (!got || cyc != last_due) begin
      errors++;
      $display("FAIL latency valid_edge got=%0d exp=%0d seen=%b", cyc, last_due, got);
    end
    checks++;
    if (out_data !== 32'h40C00000 || out_sel !== 1'b0) begin
      errors++;
      $display("FAIL latency_data got=%h/%b exp=40c00000/0", out_data, out_sel);
    end
    drain();
  endtask

  task automatic test_backpressure;
    int p0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) issue(1'(k), 32'h3F800000 + 32'(k), 5'(k));
    tick(); #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", issue_ready); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL bp_drop got=%b exp=1", drop_err); end
    repeat (R_DLY + 4) tick();
    p0 = pops;
    out_ready = 1'b1;
    drain();
    checks++;
    if (pops - p0 != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", pops - p0); end
  endtask

  task automatic test_flags;
    bit got = 1'b0;
    out_ready = 1'b1;
    tick(); sticky_clr = 1'b1; tick();
    issue(1'b1, 32'h7F800000, 5'b01000);
    drain();
    #1;
    checks++;
`ifdef FPMD_STICKY_FLAGS_EN
    if (sticky_flags !== 5'b01000) begin errors++; $display("FAIL sticky_dz got=%b exp=01000", sticky_flags); end
`else
    if (sticky_flags !== 5'b00000) begin errors++; $display("FAIL sticky_dz got=%b exp=00000", sticky_flags); end
`endif
    issue(1'b0, 32'h7F7FFFFF, 5'b00100);
    do tick(); while (cyc + 1 < last_due);
    sticky_clr = 1'b1;
    tick(); #1;
    checks++;
`ifdef FPMD_STICKY_FLAGS_EN
    if (sticky_flags !== 5'b00100) begin errors++; $display("FAIL sticky_clr_push got=%b exp=00100", sticky_flags); end
`else
    if (sticky_flags !== 5'b00000) begin errors++; $display("FAIL sticky_clr_push got=%b exp=00000", sticky_flags); end
`endif
    drain();
    issue(1'b1, 32'hFFC00000, 5'b11111);
    for (int k = 0; k < R_DLY + 10 && !got; k++) begin
      tick(); #1;
      if (out_valid) got = 1'b1;
    end
    checks++;
    if (out_flags !== 5'b11111 || out_sel !== 1'b1) begin
      errors++;
      $display("FAIL all_flags got=%b/%b exp=11111/1", out_flags, out_sel);
    end
    checks++;
`ifdef FPMD_STICKY_FLAGS_EN
    if (sticky_flags !== 5'b11111) begin errors++; $display("FAIL sticky_all got=%b exp=11111", sticky_flags); end
`else
    if (sticky_flags !== 5'b00000) begin errors++; $display("FAIL sticky_all got=%b exp=00000", sticky_flags); end
`endif
    drain();
  endtask

  task automatic test_back_to_back;
    int p0 = pops;
    int a0 = accepted;
    for (int k = 0; k < 40; k++) begin
      issue(1'($urandom), $urandom, 5'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
    drain();
    checks++;
    if (pops - p0 != accepted - a0) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=%0d", pops - p0, accepted - a0);
    end
  endtask

  task automatic test_reset_inflight;
    bit seen = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) issue(1'b0, 32'hC0000000 + 32'(k), 5'b00001);
    repeat (5) tick();
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rif_out got=%b/%h exp=0/0", out_valid, out_data); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rif_ready got=%b exp=1", issue_ready); end
    checks++; if (drop_err !== 1'b0 || sticky_flags !== 5'h0) begin errors++; $display("FAIL rif_sticky got=%b/%b exp=0/0", drop_err, sticky_flags); end
    repeat (R_DLY + 2) begin
      tick(); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rif_emerged got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_flags();
    test_back_to_back();
    test_reset_inflight();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_result_collector.md
FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

Interface
REQ-001 SHALL have parameter R_DLY, default 23, meaning core latency in cycles from operand issue to valid R/flags.
REQ-002 SHALL have parameter DEPTH, default 4, meaning result buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port arst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  in  1  issue strobe, sampled with the operands presented to the mult/div core.
REQ-006 SHALL have port sel  in  1  operation at issue: 0 = mult, 1 = div.
REQ-007 SHALL have port R  in  32  core result, IEEE-754 single.
REQ-008 SHALL have port core_flags  in  5  core flags {io, dz, of, uf, i}, msb first.
REQ-009 SHALL have port issue_ready  out  1  credit available; upstream issues only when high.
REQ-010 SHALL have port out_valid  out  1  result entry available.
REQ-011 SHALL have port out_ready  in  1  consumer accepts the entry.
REQ-012 SHALL have port out_data  out  32  result.
REQ-013 SHALL have port out_flags  out  5  flags of the result.
REQ-014 SHALL have port out_sel  out  1  operation of the result.
REQ-015 SHALL have port sticky_clr  in  1  clears sticky_flags.
REQ-016 SHALL have port sticky_flags  out  5  OR of all captured flags since the last clear.
REQ-017 SHALL have port drop_err  out  1  sticky: an issue was attempted without credit.

Function
REQ-018 An issue SHALL be accepted at an edge where en=1 and issue_ready=1.
REQ-019 Accepted issues SHALL enter an R_DLY-stage valid/sel delay line; the exiting stage pushes {R, core_flags, sel} into the buffer at that edge, exactly R_DLY edges after acceptance.
REQ-020 The buffer SHALL be first-word-fall-through; out_valid is high from the cycle after the push until an edge with out_valid=1 and out_ready=1.
REQ-021 Entries SHALL leave in issue order; out_data, out_flags and out_sel SHALL hold steady while out_valid=1 and out_ready=0.
REQ-022 inflight SHALL increment on accept and decrement on push; both at one edge leaves it unchanged.
REQ-023 issue_ready SHALL equal (inflight + occupancy) < DEPTH, from registered counters only; a pop frees a credit only in the following cycle.
REQ-024 The buffer SHALL never overflow; a push and a pop at the same edge with the buffer full SHALL leave occupancy at DEPTH.
REQ-025 en=1 with issue_ready=0 SHALL be ignored and SHALL set drop_err at that edge; only reset clears drop_err.
REQ-026 Each push SHALL OR core_flags into sticky_flags; sticky_clr with a push at the same edge SHALL load exactly that push's flags.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 At an edge with arst=0: delay line, inflight, occupancy, pointers, sticky_flags and drop_err SHALL clear, and ops in flight are discarded.
REQ-029 After reset: out_valid=0, out_data=0, out_flags=0, out_sel=0, sticky_flags=0, drop_err=0, issue_ready=1.

Configuration
REQ-030 With macro FPMD_STICKY_FLAGS_EN defined, REQ-026 applies; with it undefined, sticky_flags SHALL be tied to 0, sticky_clr is ignored, and no sticky register is built.

Structure
REQ-031 Package fpmd_pkg SHALL hold the fp_flags_t typedef, flag index constants (IO, DZ, OF, UF, I), the result entry struct {data, flags, sel} and the R_DLY default.
REQ-032 The buffer SHALL be the sub-module fpmd_sync_fifo (FWFT, DEPTH entries, full/empty/count outputs).

Verification
REQ-033 Accept at edge 10, model R=0x40C00000 and flags=0 at edge 33 -> out_valid in cycle 34 with out_data=0x40C00000, out_sel=0.
REQ-034 DEPTH=4, out_ready=0, en held 5 cycles -> issue_ready low after the 4th accept, drop_err=1, exactly 4 entries output in order when out_ready rises.
REQ-035 A div pushed with dz flag (0b01000) -> out_flags=0b01000, sticky_flags=0b01000; later sticky_clr at the same edge as a push with of (0b00100) -> sticky_flags=0b00100.
REQ-036 Buffer full with out_ready=1 and a push at the same edge -> occupancy stays 4, no entry lost or duplicated.
REQ-037 arst=0 for 1 edge with 3 ops in flight -> all outputs at reset values, no entry emerges during the following R_DLY+2 cycles.
REQ-038 Build without FPMD_STICKY_FLAGS_EN, push flags 0b11111 -> sticky_flags=0, out_flags=0b11111.
